// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment driver with frame-boundary updates and dead time.
// Optional build macro LEADING_ZERO_BLANK_EN darkens digits above the most significant non-zero nibble.
module sseg_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 500,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET,
  input  logic [4*N_DIGITS-1:0] i_DATA,
  input  logic [N_DIGITS-1:0]   i_DP,
  input  logic [N_DIGITS-1:0]   i_BLANK,
  input  logic                  i_LOAD,
  output logic [6:0]            o_SEG,
  output logic                  o_DP,
  output logic [N_DIGITS-1:0]   o_AN,
  output logic                  o_PENDING,
  output logic                  o_FRAME
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PW-1:0]       PRESC_TC = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]       DEAD_END = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  // Active-high segment pattern {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

  // Scan timing state
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          frame_q, frame_d;

  // Staged and displayed values
  logic [4*N_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                  pending_q, pending_d;
  logic [4*N_DIGITS-1:0] disp_data_q, disp_data_d;
  logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [N_DIGITS-1:0]   disp_blank_q, disp_blank_d;

  // Registered pin drivers
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic tc;
  logic frame_end;

  assign tc        = (presc_q == PRESC_TC);
  assign frame_end = tc && (idx_q == IDX_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    presc_d = tc ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    frame_d = frame_end;
  end

  // A load in the frame-end cycle goes straight to the display, so it is never left pending.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pending_d    = pending_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (frame_end) begin
      if (i_LOAD) begin
        disp_data_d  = i_DATA;
        disp_dp_d    = i_DP;
        disp_blank_d = i_BLANK;
      end else if (pending_q) begin
        disp_data_d  = pend_data_q;
        disp_dp_d    = pend_dp_q;
        disp_blank_d = pend_blank_q;
      end
      pending_d = 1'b0;
    end else if (i_LOAD) begin
      pend_data_d  = i_DATA;
      pend_dp_d    = i_DP;
      pend_blank_d = i_BLANK;
      pending_d    = 1'b1;
    end
  end

  // Current-digit selection and lit decision
  logic [3:0]          nib_cur;
  logic                blank_cur;
  logic                dp_cur;
  logic                supp_cur;
  logic [N_DIGITS-1:0] onehot;
  logic                active;
  logic                lit;
  logic                seg_on;
  logic                dp_on;

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lz_mask;
  logic                zeros_above;

  // Digit k is suppressed when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz_mask     = '0;
    zeros_above = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zeros_above = zeros_above && (disp_data_q[4*k +: 4] == 4'h0);
      lz_mask[k]  = zeros_above;
    end
  end
`endif

  always_comb begin
    nib_cur   = '0;
    blank_cur = 1'b1;
    dp_cur    = 1'b0;
    supp_cur  = 1'b0;
    onehot    = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib_cur   = disp_data_q[4*k +: 4];
        blank_cur = disp_blank_q[k];
        dp_cur    = disp_dp_q[k];
        onehot[k] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        supp_cur  = lz_mask[k];
`endif
      end
    end
  end

  always_comb begin
    active = (presc_q >= DEAD_END);
    lit    = active && !blank_cur;
    seg_on = lit && !supp_cur;
    dp_on  = lit && dp_cur;
    // A suppressed digit keeps its anode only to show its decimal point.
    seg_d  = (seg_on ? hex_to_seg(nib_cur) : 7'h00) ^ SEG_OFF;
    dp_d   = dp_on ^ DP_OFF;
    an_d   = ((seg_on || dp_on) ? onehot : '0) ^ AN_OFF;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: display and pin registers are all reset so the outputs are dark and X-free straight out of reset.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      presc_q      <= '0;
      idx_q        <= '0;
      frame_q      <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pending_q    <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign o_SEG     = seg_q;
  assign o_DP      = dp_q;
  assign o_AN      = an_q;
  assign o_PENDING = pending_q;
  assign o_FRAME   = frame_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: 4 digits, 8-cycle slots, 2 dead cycles, active-low anodes.
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_pending;
  logic        o_frame;

  int tests_run    = 0;
  int tests_failed = 0;

  // One captured frame: 4 slots x 8 cycles
  logic [3:0] g_an[32];
  logic [6:0] g_seg[32];
  logic       g_dp[32];
  logic       g_frame[32];
  logic       g_pend[32];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LIT_LZ = 4'b0011;
`else
  localparam logic [3:0] LIT_LZ = 4'b1111;
`endif

  sseg_scan_driver #(
    .N_DIGITS      (4),
    .REFRESH_DIV   (8),
    .DEAD_CYCLES   (2),
    .SEG_ACTIVE_LOW(0),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .i_CLK    (clk),
    .i_RESET  (rst),
    .i_DATA   (data),
    .i_DP     (dp),
    .i_BLANK  (blank),
    .i_LOAD   (load),
    .o_SEG    (o_seg),
    .o_DP     (o_dp),
    .o_AN     (o_an),
    .o_PENDING(o_pending),
    .o_FRAME  (o_frame)
  );

  always #5 clk = ~clk;

  // Expected {an, seg, dp} for frame cycle j given which slots are lit and their patterns.
  function automatic logic [11:0] exp_sample(input logic [3:0] lit, input logic [27:0] segs,
                                             input logic [3:0] dps, input int j);
    int         slot = j / 8;
    int         pr   = j % 8;
    logic [3:0] an   = 4'hF;
    logic [6:0] s    = 7'h00;
    logic       d    = 1'b0;
    if (pr >= 2 && lit[slot]) begin
      an = ~(4'b0001 << slot);
      s  = segs[7*slot +: 7];
      d  = dps[slot];
    end
    return {an, s, d};
  endfunction

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    data  = d;
    dp    = p;
    blank = b;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_frame(output bit found);
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (o_frame) found = 1'b1;
    end
  endtask

  // Starts on the sample where o_FRAME is high; cycle j reflects slot j/8, prescaler j%8.
  task automatic grab_frame();
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      g_an[j]    = o_an;
      g_seg[j]   = o_seg;
      g_dp[j]    = o_dp;
      g_frame[j] = o_frame;
      g_pend[j]  = o_pending;
    end
  endtask

  task automatic test_reset();
    bit found;
    rst = 1'b1; data = '0; dp = '0; blank = '0; load = 1'b0;
    #1;
    tests_run++;
    if ({o_an, o_seg, o_dp, o_pending, o_frame} !== {4'hF, 7'h00, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_async: got an=%b seg=%b dp=%b pend=%b frame=%b, want 1111 0000000 0 0 0",
               o_an, o_seg, o_dp, o_pending, o_frame);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_frame(found);
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL reset_frame_pulse: got no o_FRAME within 80 cycles, want one per 32");
    end
    grab_frame();
    for (int j = 0; j < 32; j++) begin
      tests_run++;
      if ({g_an[j], g_seg[j], g_dp[j], g_pend[j], g_frame[j]} !== {4'hF, 7'h00, 1'b0, 1'b0, (j == 31)}) begin
        tests_failed++;
        $display("FAIL reset_dark cyc%0d: got an=%b seg=%b dp=%b pend=%b frame=%b, want 1111 0000000 0 0 %b",
                 j, g_an[j], g_seg[j], g_dp[j], g_pend[j], g_frame[j], (j == 31));
      end
    end
  endtask

  task automatic test_basic_scan();
    bit found;
    do_load(16'h1A9F, 4'b0000, 4'b0000);
    tests_run++;
    if (o_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_pending_set: got %b want 1", o_pending);
    end
    wait_frame(found);
    tests_run++;
    if (!found || o_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_commit: got found=%b pend=%b want found=1 pend=0", found, o_pending);
    end
    grab_frame();
    for (int j = 0; j < 32; j++) begin
      logic [11:0] want;
      want = exp_sample(4'b1111, {7'b0110000, 7'b1110111, 7'b1111011, 7'b1000111}, 4'b0000, j);
      tests_run++;
      if ({g_an[j], g_seg[j], g_dp[j]} !== want || g_pend[j] !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_1A9F cyc%0d: got an=%b seg=%b dp=%b pend=%b, want an=%b seg=%b dp=%b pend=0",
                 j, g_an[j], g_seg[j], g_dp[j], g_pend[j], want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_pending_hold();
    bit found;
    bit held = 1'b1;
    do_load(16'h1234, 4'b0000, 4'b0000);
    @(negedge clk);
    do_load(16'h5678, 4'b0000, 4'b0000);
    tests_run++;
    if ({o_pending, o_an, o_seg} !== {1'b1, 4'b1110, 7'b1000111}) begin
      tests_failed++;
      $display("FAIL pend_old_held: got pend=%b an=%b seg=%b want 1 1110 1000111", o_pending, o_an, o_seg);
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (o_frame) found = 1'b1;
      else if (o_pending !== 1'b1) held = 1'b0;
    end
    tests_run++;
    if (!found || !held || o_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL pend_until_fe: got found=%b held=%b pend_at_fe=%b want 1 1 0", found, held, o_pending);
    end
    grab_frame();
    for (int j = 0; j < 32; j++) begin
      logic [11:0] want;
      want = exp_sample(4'b1111, {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111}, 4'b0000, j);
      tests_run++;
      if ({g_an[j], g_seg[j], g_dp[j]} !== want || g_pend[j] !== 1'b0) begin
        tests_failed++;
        $display("FAIL pend_5678 cyc%0d: got an=%b seg=%b dp=%b pend=%b, want an=%b seg=%b dp=%b pend=0",
                 j, g_an[j], g_seg[j], g_dp[j], g_pend[j], want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_load_at_fe();
    bit saw_pend = 1'b0;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      if (o_pending !== 1'b0) saw_pend = 1'b1;
    end
    data  = 16'h00C0;
    dp    = 4'b0010;
    blank = 4'b0000;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    tests_run++;
    if (o_frame !== 1'b1 || o_pending !== 1'b0 || saw_pend) begin
      tests_failed++;
      $display("FAIL fe_bypass: got frame=%b pend=%b saw_pend=%b want 1 0 0", o_frame, o_pending, saw_pend);
    end
    grab_frame();
    for (int j = 0; j < 32; j++) begin
      logic [11:0] want;
      want = exp_sample(LIT_LZ, {7'b1111110, 7'b1111110, 7'b1001110, 7'b1111110}, 4'b0010, j);
      tests_run++;
      if ({g_an[j], g_seg[j], g_dp[j]} !== want || g_pend[j] !== 1'b0) begin
        tests_failed++;
        $display("FAIL fe_00C0 cyc%0d: got an=%b seg=%b dp=%b pend=%b, want an=%b seg=%b dp=%b pend=0",
                 j, g_an[j], g_seg[j], g_dp[j], g_pend[j], want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_blank();
    bit found;
    do_load(16'h8888, 4'b0000, 4'b0101);
    wait_frame(found);
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL blank_frame: got no o_FRAME within 80 cycles");
    end
    grab_frame();
    for (int j = 0; j < 32; j++) begin
      logic [11:0] want;
      want = exp_sample(4'b1010, {4{7'b1111111}}, 4'b0000, j);
      tests_run++;
      if ({g_an[j], g_seg[j], g_dp[j]} !== want) begin
        tests_failed++;
        $display("FAIL blank_8888 cyc%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 j, g_an[j], g_seg[j], g_dp[j], want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_zero_digits();
    bit found;
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_frame(found);
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL zero_frame: got no o_FRAME within 80 cycles");
    end
    grab_frame();
    for (int j = 0; j < 32; j++) begin
      logic [11:0] want;
      want = exp_sample(LIT_LZ, {7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110}, 4'b0000, j);
      tests_run++;
      if ({g_an[j], g_seg[j], g_dp[j]} !== want) begin
        tests_failed++;
        $display("FAIL zero_0050 cyc%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 j, g_an[j], g_seg[j], g_dp[j], want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    bit found;
    do_load(16'h1234, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    tests_run++;
    if ({o_an, o_seg, o_pending} !== {4'b1110, 7'b1111110, 1'b1}) begin
      tests_failed++;
      $display("FAIL midrun_pre: got an=%b seg=%b pend=%b want 1110 1111110 1", o_an, o_seg, o_pending);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({o_an, o_seg, o_dp, o_pending, o_frame} !== {4'hF, 7'h00, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrun_reset: got an=%b seg=%b dp=%b pend=%b frame=%b want 1111 0000000 0 0 0",
               o_an, o_seg, o_dp, o_pending, o_frame);
    end
    #1 rst = 1'b0;
    wait_frame(found);
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL midrun_frame: got no o_FRAME within 80 cycles");
    end
    grab_frame();
    for (int j = 0; j < 32; j++) begin
      tests_run++;
      if ({g_an[j], g_seg[j], g_dp[j], g_pend[j], g_frame[j]} !== {4'hF, 7'h00, 1'b0, 1'b0, (j == 31)}) begin
        tests_failed++;
        $display("FAIL midrun_dark cyc%0d: got an=%b seg=%b dp=%b pend=%b frame=%b, want 1111 0000000 0 0 %b",
                 j, g_an[j], g_seg[j], g_dp[j], g_pend[j], g_frame[j], (j == 31));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_pending_hold();
    test_load_at_fe();
    test_blank();
    test_zero_digits();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
